adc_spi_responder: RTL
======================

// Module: adc_spi_responder
// PURPOSE
//  SPI responder emulating a 2-channel 12-bit serial ADC (MCP3202-style command frame) on the far
//  end of the adc_interface link. Feeds adc_data_in from register/DIP-supplied channel values so
//  the dial and CdS paths (phase 2, event 1) run on boards or benches without analog parts.
//  Oversamples the master's CS_n/SCLK/DIN with clk; SCLK is never used as a clock.
// PARAMETERS
//  SYNC_STAGES  2      synchronizer depth on cs_n/sclk/din (>=2)
//  DATA_W       12     conversion width; bit counters sized from this
//  IDLE_DOUT    1'b0   level driven on adc_dout outside the data window
// PORTS
//  clk          in   1       system clock (50 MHz)
//  rst_n        in   1       asynchronous, active-low reset
//  adc_cs_n     in   1       chip select from master, active low
//  adc_sclk     in   1       serial clock from master, idle low
//  adc_din      in   1       command bits from master (MOSI)
//  adc_dout     out  1       conversion data to master (MISO)
//  ch0_value    in   DATA_W  value returned for channel 0 (dial)
//  ch1_value    in   DATA_W  value returned for channel 1 (CdS)
//  busy         out  1       high from CS_n fall until frame ends/aborts
//  conv_done    out  1       1-clk pulse when master samples B0
//  conv_ch      out  1       channel of last completed conversion (valid with/after conv_done)
//  frame_err    out  1       1-clk pulse when CS_n rises before B0 was sampled
// BEHAVIOUR
//  Reset: adc_dout=IDLE_DOUT, busy=0, conv_done=0, conv_ch=0, frame_err=0, state=IDLE, counters 0.
//  Inputs pass SYNC_STAGES flops; edges detected on synced copies; outputs update <=SYNC_STAGES+1 clk
//   after the pin edge. Master SCLK half-period must be >= SYNC_STAGES+2 clk; faster is unsupported.
//  Master samples DIN/DOUT on SCLK rising; responder changes adc_dout only on SCLK falling edges.
//  FSM:
//   IDLE  : CS_n low -> START, busy=1.
//   START : each rise: DIN=0 -> stay (leading zeros ignored); DIN=1 -> CMD, cmd_cnt=0.
//   CMD   : rises 1..3 capture SGL, ODD, MSBF. On the MSBF rise latch sample (DATA_W) -> DATA.
//   DATA  : fall 0 drives null bit 0; falls 1..12 drive B11..B0. Next rise (B0 sampled) pulses
//           conv_done, sets conv_ch=ODD. Then MSBF=1 -> HOLD; MSBF=0 -> TAIL.
//   TAIL  : falls 1..11 drive B1..B11 (LSB-first repeat), then -> HOLD.
//   HOLD  : adc_dout=IDLE_DOUT on every further fall; extra clocks harmless.
//  Sample value: SGL=1: ODD?ch1:ch0. SGL=0: ODD=0 -> ch0-ch1, ODD=1 -> ch1-ch0, saturate at 0
//   (unsigned, no wrap). Latched once per frame; ch*_value changes mid-frame do not affect it.
//  CS_n high (any state): next clk -> IDLE, busy=0, adc_dout=IDLE_DOUT. If state was START/CMD/
//   DATA (B0 not yet sampled) pulse frame_err; from TAIL/HOLD no error. CS_n high while SCLK edge
//   is detected same clk: CS_n wins, edge ignored.
//  CS_n low again right after rise: new frame from START; no state carried over except conv_ch.
//  rst_n low mid-frame: immediate reset values, no conv_done/frame_err pulse.
// TESTING
//  1 Reset: rst_n low with SCLK toggling -> adc_dout=0, busy=0, no pulses; release -> IDLE.
//  2 ch0=0xABC, frame start,SGL=1,ODD=0,MSBF=1, 17 SCLKs -> null 0 then 1010_1011_1100, conv_done
//    once, conv_ch=0.
//  3 SGL=0,ODD=0, ch0=0x100, ch1=0x200 -> 0x000 (saturated); ODD=1 -> 0x100, conv_ch=1.
//  4 3 leading zero bits before start, ch1=0xFFF SGL=1,ODD=1 -> 12 ones; ch1 set 0x000 after MSBF
//    rise -> still 0xFFF.
//  5 MSBF=0, ch0=0x801 -> MSB-first 0x801, then B1..B11 = 0,0,...,0,1, then zeros.
//  6 CS_n high after 6th data bit -> frame_err 1 clk, no conv_done, busy=0, next frame correct.

Source files
------------

// File: rtl/adc_spi_responder.sv
// SPI responder that emulates a 2-channel 12-bit serial ADC (MCP3202-style frame).
// All master pins are oversampled with clk; SCLK is only ever treated as data.
module adc_spi_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DATA_W      = 12,
    parameter logic IDLE_DOUT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_cs_n,
    input  logic              adc_sclk,
    input  logic              adc_din,
    output logic              adc_dout,
    input  logic [DATA_W-1:0] ch0_value,
    input  logic [DATA_W-1:0] ch1_value,
    output logic              busy,
    output logic              conv_done,
    output logic              conv_ch,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] TAIL_END = CNT_W'(DATA_W - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_CMD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_TAIL  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sclk_d;

    state_t             r_state;
    logic [1:0]         r_cmd_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_sgl;
    logic               r_odd;
    logic               r_msbf;
    logic [DATA_W-1:0]  r_shift;
    logic               r_dout;
    logic               r_busy;
    logic               r_conv_done;
    logic               r_conv_ch;
    logic               r_frame_err;

    logic               w_cs_n;
    logic               w_sclk;
    logic               w_din;
    logic               w_rise;
    logic               w_fall;
    logic [DATA_W:0]    w_diff;
    logic [DATA_W-1:0]  w_sample;

    // Synchronizer chains plus the delayed SCLK copy used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_din_sync  <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_din  = r_din_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_d;
    assign w_fall = ~w_sclk & r_sclk_d;

    // Conversion result: single-ended pick or pseudo-differential, clamped at zero
    always_comb begin
        w_diff   = '0;
        w_sample = '0;
        if (r_sgl) begin
            w_sample = r_odd ? ch1_value : ch0_value;
        end else begin
            w_diff   = r_odd ? ({1'b0, ch1_value} - {1'b0, ch0_value})
                             : ({1'b0, ch0_value} - {1'b0, ch1_value});
            w_sample = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
        end
    end

    // Frame state machine; r_shift rotates so the LSB-first tail can reuse it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_cnt   <= 2'd0;
            r_bit_cnt   <= '0;
            r_sgl       <= 1'b0;
            r_odd       <= 1'b0;
            r_msbf      <= 1'b0;
            r_shift     <= '0;
            r_dout      <= IDLE_DOUT;
            r_busy      <= 1'b0;
            r_conv_done <= 1'b0;
            r_conv_ch   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_n) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_dout    <= IDLE_DOUT;
                r_cmd_cnt <= 2'd0;
                r_bit_cnt <= '0;
                if (r_state == ST_START || r_state == ST_CMD || r_state == ST_DATA) begin
                    r_frame_err <= 1'b1;
                end else begin
                    r_frame_err <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                        r_sgl   <= 1'b0;
                        r_odd   <= 1'b0;
                        r_msbf  <= 1'b0;
                    end
                    ST_START: begin
                        if (w_rise && w_din) begin
                            r_state   <= ST_CMD;
                            r_cmd_cnt <= 2'd0;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_cmd_cnt <= r_cmd_cnt + 2'd1;
                            case (r_cmd_cnt)
                                2'd0:    r_sgl <= w_din;
                                2'd1:    r_odd <= w_din;
                                default: begin
                                    r_msbf    <= w_din;
                                    r_shift   <= w_sample;
                                    r_bit_cnt <= '0;
                                    r_state   <= ST_DATA;
                                end
                            endcase
                        end
                    end
                    ST_DATA: begin
                        if (w_fall && r_bit_cnt != DATA_END) begin
                            r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (r_bit_cnt == '0) begin
                                r_dout <= 1'b0;
                            end else begin
                                r_dout  <= r_shift[DATA_W-1];
                                r_shift <= {r_shift[DATA_W-2:0], r_shift[DATA_W-1]};
                            end
                        end else if (w_rise && r_bit_cnt == DATA_END) begin
                            r_conv_done <= 1'b1;
                            r_conv_ch   <= r_odd;
                            r_bit_cnt   <= '0;
                            r_state     <= r_msbf ? ST_HOLD : ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        if (w_fall) begin
                            r_dout  <= r_shift[1];
                            r_shift <= {r_shift[0], r_shift[DATA_W-1:1]};
                            if (r_bit_cnt == TAIL_END) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_fall) begin
                            r_dout <= IDLE_DOUT;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_dout  <= IDLE_DOUT;
                    end
                endcase
            end
        end
    end

    assign adc_dout  = r_dout;
    assign busy      = r_busy;
    assign conv_done = r_conv_done;
    assign conv_ch   = r_conv_ch;
    assign frame_err = r_frame_err;

endmodule
